// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: FSM state encoding and the
// write masks accepted when the DMEM_MASK_CHECK_EN build option is enabled.
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam logic [3:0] MASK_B0 = 4'b0001;
    localparam logic [3:0] MASK_B1 = 4'b0010;
    localparam logic [3:0] MASK_B2 = 4'b0100;
    localparam logic [3:0] MASK_B3 = 4'b1000;
    localparam logic [3:0] MASK_H0 = 4'b0011;
    localparam logic [3:0] MASK_H1 = 4'b1100;
    localparam logic [3:0] MASK_W  = 4'b1111;

    function automatic logic mask_is_legal(input logic [3:0] be);
        case (be)
            MASK_B0, MASK_B1, MASK_B2, MASK_B3,
            MASK_H0, MASK_H1, MASK_W: return 1'b1;
            default:                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_merge.sv
// Byte-lane merge of store data into an existing memory word.
module dmem_lane_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] merged_word
);

    always_comb begin
        merged_word = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) merged_word[8*i +: 8] = wdata[8*i +: 8];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder with byte-masked writes.
// Define DMEM_MASK_CHECK_EN to add the mem_error port and illegal-mask suppression.
//
// state | meaning
// IDLE  | waiting for mem_read/mem_write; request latched on acceptance
// WAIT  | latency countdown; inputs ignored
// RESP  | mem_resp pulse; write commits on the edge leaving this state
module dmem_responder
    import rv32i_types::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_address,
    input  logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_resp
`ifdef DMEM_MASK_CHECK_EN
   ,output logic        mem_error
`endif
);

    localparam int         DEPTH  = 2 ** ADDR_WIDTH;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    dmem_state_t           state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [3:0]            be_q, be_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  wr_q, wr_d;
    logic [31:0]           rdata_q, rdata_d;

    logic [31:0] mem_q [DEPTH];
    logic [31:0] merged_word;
    logic        wr_commit;

    // Address bits outside the word index are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_address[31:ADDR_WIDTH+2], mem_address[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        unique case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    idx_d   = mem_address[ADDR_WIDTH+1:2];
                    be_d    = mem_byte_enable;
                    wdata_d = mem_wdata;
                    wr_d    = mem_write;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Sampled before the write so a combined read/write returns the old word.
        rdata_d = rdata_q;
        if (state_d == RESP && state_q != RESP) rdata_d = mem_q[idx_d];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            wr_q    <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
        end
    end

    dmem_lane_merge u_lane_merge (
        .old_word    (mem_q[idx_q]),
        .wdata       (wdata_q),
        .be          (be_q),
        .merged_word (merged_word)
    );

`ifdef DMEM_MASK_CHECK_EN
    assign wr_commit = wr_q && mask_is_legal(be_q);
    assign mem_error = (state_q == RESP) && wr_q && !mask_is_legal(be_q);
`else
    assign wr_commit = wr_q;
`endif

    // Array is deliberately outside reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (state_q == RESP && wr_commit) mem_q[idx_q] <= merged_word;
    end

    assign mem_resp  = (state_q == RESP);
    assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: the driver queues expected responses,
// the monitor checks every mem_resp pulse against the queue head.
module tb_dmem_responder;

    localparam int LATENCY = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] mem_address = 32'd0;
    logic [3:0]  mem_byte_enable = 4'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic [31:0] mem_rdata;
    logic        mem_resp;
`ifdef DMEM_MASK_CHECK_EN
    logic        mem_error;
`endif

    typedef struct {
        logic        chk_rd;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    dmem_responder #(.ADDR_WIDTH(8), .LATENCY(LATENCY)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_byte_enable (mem_byte_enable),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp)
`ifdef DMEM_MASK_CHECK_EN
       ,.mem_error       (mem_error)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef DMEM_MASK_CHECK_EN
    function automatic logic tb_mask_legal(input logic [3:0] be);
        case (be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction
`endif

    // Monitor
    always @(negedge clk) begin
        if (mem_resp === 1'b1) begin
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp: got mem_resp=1 at cycle %0d, required no response", cyc);
            end else begin
                e = sb.pop_front();
                if (cyc != e.cyc) begin
                    errors++;
                    $display("FAIL resp_latency: got cycle %0d, required %0d", cyc, e.cyc);
                end
                if (e.chk_rd) begin
                    checks++;
                    if (mem_rdata !== e.rdata) begin
                        errors++;
                        $display("FAIL rdata: got %08h, required %08h", mem_rdata, e.rdata);
                    end
                end
`ifdef DMEM_MASK_CHECK_EN
                checks++;
                if (mem_error !== e.err) begin
                    errors++;
                    $display("FAIL mem_error: got %b, required %b", mem_error, e.err);
                end
`endif
            end
        end
    end

    task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd,
                          input logic chk, input logic [31:0] exp_rd, input logic scramble);
        exp_t e;
        bit   seen;
        e.chk_rd = chk;
        e.rdata  = exp_rd;
        e.err    = 1'b0;
`ifdef DMEM_MASK_CHECK_EN
        e.err    = wr && !tb_mask_legal(be);
`endif
        // Accepted at the next edge; pulse visible in the cycle before edge accept+LATENCY.
        e.cyc    = cyc + LATENCY;
        sb.push_back(e);
        mem_read        = rd;
        mem_write       = wr;
        mem_address     = addr;
        mem_byte_enable = be;
        mem_wdata       = wd;
        @(posedge clk);
        #1;
        if (scramble) begin
            mem_address     = 32'h0000_0020;
            mem_wdata       = 32'h5A5A_5A5A;
            mem_byte_enable = 4'b1111;
            mem_write       = 1'b1;
        end
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (mem_resp === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: got no mem_resp for addr %08h, required one", addr);
            sb.delete();
        end
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic wr_word(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
        do_req(1'b0, 1'b1, addr, be, wd, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic rd_word(input logic [31:0] addr, input logic [31:0] exp_rd);
        do_req(1'b1, 1'b0, addr, 4'd0, 32'd0, 1'b1, exp_rd, 1'b0);
    endtask

    task automatic chk_val(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %08h, required %08h", name, got, req);
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst = 1'b0;
        #1;
        chk_val("reset_resp", {31'd0, mem_resp}, 32'd0);
        chk_val("reset_rdata", mem_rdata, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Full-word write and read back
        wr_word(32'h10, 4'b1111, 32'hDEAD_BEEF);
        rd_word(32'h10, 32'hDEAD_BEEF);

        // Single-lane merge
        wr_word(32'h20, 4'b1111, 32'h1122_3344);
        wr_word(32'h20, 4'b0010, 32'h0000_AB00);
        rd_word(32'h20, 32'h1122_AB44);

        // Index wraps modulo 256 words
        wr_word(32'h400, 4'b1111, 32'hCAFE_F00D);
        rd_word(32'h000, 32'hCAFE_F00D);

        // Reset in WAIT aborts the write and its response
        wr_word(32'h30, 4'b1111, 32'h3030_3030);
        mem_write = 1'b1; mem_address = 32'h30;
        mem_byte_enable = 4'b1111; mem_wdata = 32'hFFFF_FFFF;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk_val("abort_resp", {31'd0, mem_resp}, 32'd0);
        chk_val("abort_rdata", mem_rdata, 32'd0);
        mem_write = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rd_word(32'h30, 32'h3030_3030);

        // Read+write together: old word returned, new word stored
        wr_word(32'h40, 4'b1111, 32'h0000_0001);
        do_req(1'b1, 1'b1, 32'h40, 4'b1111, 32'h0000_0002, 1'b1, 32'h0000_0001, 1'b0);
        rd_word(32'h40, 32'h0000_0002);

        // Empty mask changes nothing; upper-half mask
        wr_word(32'h50, 4'b1111, 32'hAABB_CCDD);
        wr_word(32'h50, 4'b0000, 32'h1111_1111);
        rd_word(32'h50, 32'hAABB_CCDD);
        wr_word(32'h52, 4'b1100, 32'h1234_0000);
        rd_word(32'h50, 32'h1234_CCDD);

        // Inputs changing after acceptance are ignored
        do_req(1'b1, 1'b0, 32'h10, 4'd0, 32'd0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        rd_word(32'h20, 32'h1122_AB44);

        // Mask 0110: illegal under the mask check, plain write otherwise
        wr_word(32'h50, 4'b0110, 32'h9999_9999);
`ifdef DMEM_MASK_CHECK_EN
        rd_word(32'h50, 32'h1234_CCDD);
`else
        rd_word(32'h50, 32'h1299_99DD);
`endif

        repeat (5) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_resp: got %0d outstanding responses, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, log2 of the memory depth in 32-bit words.
REQ-002 Parameter LATENCY, default 3, cycles from request acceptance to mem_resp; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous reset, active-low.
REQ-005 mem_read  input  1  load request; held by the requester until mem_resp.
REQ-006 mem_write  input  1  store request; held by the requester until mem_resp.
REQ-007 mem_address  input  32  byte address; bits [1:0] are ignored for indexing.
REQ-008 mem_byte_enable  input  4  write lane mask; bit i selects mem_wdata[8i+7:8i].
REQ-009 mem_wdata  input  32  store data, already lane-aligned by the requester.
REQ-010 mem_rdata  output  32  full addressed word; valid only while mem_resp=1.
REQ-011 mem_resp  output  1  one-cycle completion pulse.
REQ-012 mem_error  output  1  misaligned-mask flag; present only under DMEM_MASK_CHECK_EN.

Function
REQ-013 FSM states IDLE, WAIT, RESP.
REQ-014 IDLE: if mem_read or mem_write is 1 at a rising edge, latch the address, mask, data and operation, and load the latency counter; otherwise stay in IDLE.
REQ-015 LATENCY=1: IDLE goes directly to RESP; LATENCY>1: IDLE goes to WAIT with counter=LATENCY-1.
REQ-016 WAIT: counter decrements each cycle; go to RESP on the edge where counter=1.
REQ-017 mem_resp is 1 exactly in the cycle k+LATENCY, where k is the accepting edge; it is 0 in all other cycles.
REQ-018 RESP always goes to IDLE next cycle; the requester drops its request in the same edge, so there is no re-trigger.
REQ-019 Word index = latched mem_address[ADDR_WIDTH+1:2]; upper address bits are ignored, so addresses wrap modulo the depth.
REQ-020 Read: mem_rdata is the full 32-bit word registered on entry to RESP; lane selection and sign extension stay with the requester.
REQ-021 Write: only lanes with mem_byte_enable[i]=1 are updated, on the edge leaving RESP; other lanes are unchanged.
REQ-022 Write with mem_byte_enable=0000 completes normally with mem_resp and changes no lanes.
REQ-023 mem_read and mem_write both 1: treated as a write; mem_rdata returns the pre-write word.
REQ-024 Inputs that change while in WAIT or RESP are ignored; only the values latched at acceptance are used.
REQ-025 mem_rdata holds its last value outside RESP; this value is not specified for checking.

Reset
REQ-026 When rst=0: state=IDLE, counter=0, mem_resp=0, mem_rdata=0, mem_error=0, asynchronously.
REQ-027 Reset during WAIT or RESP aborts the transaction: no write commits, and no mem_resp is produced.
REQ-028 Memory array contents are not reset; they keep their values through reset.

Configuration
REQ-029 Macro DMEM_MASK_CHECK_EN.
REQ-030 With the macro defined, a write mask that is not in the legal set is illegal. Legal set: 0001, 0010, 0100, 1000, 0011, 1100, 1111.
REQ-031 With the macro defined, an illegal write mask sets mem_error=1 in the RESP cycle, suppresses the write, and still pulses mem_resp.
REQ-032 With the macro defined, a read never asserts mem_error.
REQ-033 Without the macro, the mem_error port and the check logic are absent, and every mask is written as given.

Structure
REQ-034 dmem_state_t (IDLE/WAIT/RESP) and the legal-mask constants are placed in package rv32i_types.
REQ-035 Sub-module dmem_lane_merge (combinational): takes the old word, wdata and mask, and returns the merged word; it is instantiated once.
REQ-036 The memory array is a logic [31:0] array with 2**ADDR_WIDTH entries, inside dmem_responder.

Verification
REQ-037 LATENCY=3, write 0xDEADBEEF with mask 1111 to 0x10, then read 0x10 -> mem_resp 3 cycles after each acceptance; rdata=0xDEADBEEF.
REQ-038 Prefill 0x11223344 at 0x20; write 0x0000AB00 with mask 0010; read 0x20 -> rdata=0x1122AB44.
REQ-039 ADDR_WIDTH=8, write 0xCAFEF00D to 0x400, then read 0x000 -> rdata=0xCAFEF00D (wrap-around).
REQ-040 Write 0xFFFFFFFF with mask 1111 to 0x30; assert rst=0 in WAIT; release; read 0x30 -> no resp for the aborted write; old data returned.
REQ-041 Read and write both asserted to 0x40 (old 0x1, wdata 0x2) -> rdata=0x1; a following read returns 0x2.
REQ-042 With DMEM_MASK_CHECK_EN, write with mask 0110 -> mem_resp=1 and mem_error=1 in the same cycle; the word is unchanged.
